// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [2:0]  imem_bank;
  logic [14:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    output imem_bank,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  imem_bank,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and FB/EB bank bits, issues one memory
// request at a time, applies execute redirects and pulses flush to decode.
module fetch_unit #(
  parameter logic [11:0] RESET_PC  = 12'o4000,
  parameter logic [14:0] NOP_INSTR = 15'o30000
) (
  input  logic         clock,
  input  logic         rst_l,
  input  logic         stall,
  input  logic         halt,
  input  logic         branch_taken,
  input  logic [11:0]  branch_target,
  input  logic         fb_we,
  input  logic         eb_we,
  input  logic [2:0]   bank_wdata,
  fetch_unit_if.master imem,
  output logic [14:0]  instr,
  output logic [11:0]  pc,
  output logic [2:0]   bits_FB,
  output logic [2:0]   bits_EB,
  output logic         instr_valid,
  output logic         flush
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [11:0] r_fetch_pc;
  logic [14:0] r_instr;
  logic [11:0] r_pc;
  logic        r_instr_valid;
  logic        r_flush;
  logic        r_imem_req;
  logic [11:0] r_imem_addr;
  logic [2:0]  r_imem_bank;
  logic        r_drop;
  logic        r_halted;
  logic [2:0]  r_fb;
  logic [2:0]  r_eb;

  logic        w_halted_next;
  logic [2:0]  w_fb_next;
  logic        w_outstanding;
  logic        w_drop_next;

  // Next-cycle halt/FB values and whether a memory response is still owed to us.
  always_comb begin
    w_halted_next = r_halted | halt;
    if (fb_we) begin
      w_fb_next = bank_wdata;
    end else begin
      w_fb_next = r_fb;
    end
    // A response arriving now settles any outstanding request (it is discarded).
    if (imem.imem_valid) begin
      w_outstanding = 1'b0;
      w_drop_next   = 1'b0;
    end else begin
      w_outstanding = (r_state == S_WAIT) || ((r_state == S_REQ) && r_imem_req) || r_drop;
      w_drop_next   = r_drop;
    end
  end

  // Bank bits and the sticky halt flag.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      r_fb     <= 3'd0;
      r_eb     <= 3'd0;
      r_halted <= 1'b0;
    end else begin
      r_fb <= w_fb_next;
      if (eb_we) begin
        r_eb <= bank_wdata;
      end
      r_halted <= w_halted_next;
    end
  end

  // Fetch FSM; imem_req is pre-registered so it is high during the REQ cycle.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_imem_bank   <= 3'd0;
      r_drop        <= 1'b0;
    end else if (branch_taken) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= branch_target;
      r_pc          <= branch_target;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_flush       <= 1'b1;
      r_drop        <= w_outstanding;
      r_imem_req    <= !w_outstanding && !w_halted_next;
      r_imem_addr   <= branch_target;
      r_imem_bank   <= w_fb_next;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        S_REQ: begin
          r_drop <= w_drop_next;
          if (r_imem_req) begin
            r_imem_req <= 1'b0;
            r_state    <= S_WAIT;
          end else if (!w_halted_next && !w_drop_next) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_pc;
            r_imem_bank <= w_fb_next;
          end else begin
            r_imem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          r_imem_req <= 1'b0;
          if (imem.imem_valid) begin
            r_instr       <= imem.imem_rdata;
            r_pc          <= r_fetch_pc;
            r_instr_valid <= 1'b1;
            r_fetch_pc    <= r_fetch_pc + 12'd1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_state       <= S_REQ;
            r_imem_req    <= !w_halted_next;
            r_imem_addr   <= r_fetch_pc;
            r_imem_bank   <= w_fb_next;
          end else begin
            r_imem_req <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_REQ;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_instr       <= NOP_INSTR;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_imem_addr;
  assign imem.imem_bank = r_imem_bank;
  assign instr          = r_instr;
  assign pc             = r_pc;
  assign bits_FB        = r_fb;
  assign bits_EB        = r_eb;
  assign instr_valid    = r_instr_valid;
  assign flush          = r_flush;

endmodule
